// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Contents:
//   loader_state_e : loader FSM states
//   HDR_BYTES      : bytes in the stream header (16-bit word count)
//   WORD_BYTES     : bytes per instruction word
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WR,
    DONE,
    ERR
  } loader_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs accepted stream bytes into a little-endian 32-bit
// word, one lane per accepted byte, and flags the byte that completes it.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clear       : restart lane counting at lane 0 (new load)
//   byte_en     : byte_in is accepted this cycle
//   byte_in     : stream byte
//   word        : assembled word including this cycle's byte (combinational)
//   word_ready  : this cycle's accepted byte is the last lane of the word
module byte_assembler
  import riscv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;

  // Each lane takes the incoming byte when it is the lane being filled,
  // otherwise it shows the previously collected value.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word[8*gi +: 8] = (byte_en && (byte_cnt_reg == 2'(gi)))
                               ? byte_in : word_reg[8*gi +: 8];
    end
  endgenerate

  assign word_ready = byte_en && (byte_cnt_reg == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'd0;
    end else if (clear) begin
      byte_cnt_reg <= 2'd0;
    end else if (byte_en) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;  // wraps 3 -> 0
      word_reg     <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that receives a byte stream (2-byte little-endian
// word count followed by that many little-endian 32-bit words), writes the
// words to instruction memory and holds the core in reset until done.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   start                 : begin a load (honoured in IDLE and DONE)
//   byte_in, byte_valid   : stream byte and its valid flag
//   byte_ready            : loader accepts byte_in this cycle
//   imem_we/addr/wdata    : one-cycle instruction-memory write port
//   core_rst              : core reset, released only once the image is loaded
//   done                  : image loaded, core running
//   err                   : header word count exceeded memory capacity
module imem_loader
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  loader_state_e     state_reg, state_next;
  logic [15:0]       len_reg;
  logic              hdr_cnt_reg;
  logic [ADDR_W:0]   word_cnt_reg;   // one extra bit so a full load does not wrap
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic              accept;
  logic              start_load;
  logic              hdr_last;
  logic              last_word;
  logic [15:0]       len_full;
  logic              asm_en;
  logic              word_ready;
  logic [31:0]       word_next;

  // byte_ready depends on state only, keeping the handshake free of loops.
  assign byte_ready = (state_reg == HDR) || (state_reg == DATA);
  assign accept     = byte_valid && byte_ready;
  assign start_load = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign hdr_last   = accept && (state_reg == HDR) && (hdr_cnt_reg == 1'(HDR_BYTES - 1));
  assign len_full   = {byte_in, len_reg[7:0]};
  assign last_word  = (17'(word_cnt_reg) + 17'd1) == {1'b0, len_reg};
  assign asm_en     = accept && (state_reg == DATA);

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .byte_en    (asm_en),
    .byte_in    (byte_in),
    .word       (word_next),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_we    = 1'b0;
    core_rst   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = HDR;
      end
      HDR: begin
        if (hdr_last) begin
          if (len_full == 16'd0)                   state_next = DONE;
          else if ({1'b0, len_full} > CAPACITY)    state_next = ERR;
          else                                     state_next = DATA;
        end
      end
      DATA: begin
        if (word_ready) state_next = WR;
      end
      WR: begin
        imem_we    = 1'b1;
        state_next = last_word ? DONE : DATA;
      end
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) state_next = HDR;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address/data are captured as the word completes, so they are
  // valid throughout WR and then hold until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg      <= 16'd0;
      hdr_cnt_reg  <= 1'b0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
    end else begin
      if (start_load) begin
        len_reg      <= 16'd0;
        hdr_cnt_reg  <= 1'b0;
        word_cnt_reg <= '0;
      end
      if (accept && (state_reg == HDR)) begin
        if (hdr_cnt_reg == 1'b0) len_reg[7:0]  <= byte_in;
        else                     len_reg[15:8] <= byte_in;
        hdr_cnt_reg <= 1'b1;
      end
      if (word_ready) begin
        addr_reg  <= word_cnt_reg[ADDR_W-1:0];
        wdata_reg <= word_next;
      end
      if (state_reg == WR) begin
        word_cnt_reg <= word_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Two instances share the stimulus:
// dut_a (ADDR_W=10) and dut_b (ADDR_W=2, for capacity limits); sel picks
// which one is observed. Expected writes come from a model that decodes
// the byte image directly.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       sel;

  logic       a_ready, a_we, a_core_rst, a_done, a_err;
  logic [9:0] a_addr;
  logic [31:0] a_wdata;
  logic       b_ready, b_we, b_core_rst, b_done, b_err;
  logic [1:0] b_addr;
  logic [31:0] b_wdata;

  logic       o_ready, o_we, o_core_rst, o_done, o_err;
  logic [9:0] o_addr;
  logic [31:0] o_wdata;

  int checks;
  int failures;

  logic [7:0]  img_q[$];
  int unsigned addr_q[$];
  logic [31:0] data_q[$];

  imem_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(a_ready), .imem_we(a_we),
    .imem_addr(a_addr), .imem_wdata(a_wdata), .core_rst(a_core_rst),
    .done(a_done), .err(a_err)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(b_ready), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .core_rst(b_core_rst),
    .done(b_done), .err(b_err)
  );

  always_comb begin
    o_ready    = sel ? b_ready    : a_ready;
    o_we       = sel ? b_we       : a_we;
    o_addr     = sel ? {8'd0, b_addr} : a_addr;
    o_wdata    = sel ? b_wdata    : a_wdata;
    o_core_rst = sel ? b_core_rst : a_core_rst;
    o_done     = sel ? b_done     : a_done;
    o_err      = sel ? b_err      : a_err;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every write and confirms no byte can be taken in WR.
  always @(negedge clk) begin
    if (o_we) begin
      addr_q.push_back(int'(o_addr));
      data_q.push_back(o_wdata);
      $display("write addr=%0d data=%08h", o_addr, o_wdata);
      check("wr_ready_low", {31'd0, o_ready}, 32'd0);
    end
  end

  // Reference: decode header and words from the image with plain arithmetic.
  task automatic compare_writes(input int unsigned cap);
    int unsigned len;
    int unsigned n_exp;
    logic [31:0] exp_data;
    len   = int'(img_q[0]) + 256 * int'(img_q[1]);
    n_exp = (len > cap) ? 0 : len;
    check("wr_count", addr_q.size(), n_exp);
    for (int w = 0; w < int'(n_exp) && w < addr_q.size(); w++) begin
      exp_data = 32'(img_q[2+4*w])
               + 32'(img_q[3+4*w]) * 32'h100
               + 32'(img_q[4+4*w]) * 32'h10000
               + 32'(img_q[5+4*w]) * 32'h1000000;
      check("wr_addr", addr_q[w], w);
      check("wr_data", data_q[w], exp_data);
    end
  endtask

  task automatic build_image(input int unsigned len);
    img_q.delete();
    img_q.push_back(8'(len));
    img_q.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * int'(len); i++) img_q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input int limit, output bit ok);
    int waited;
    ok = 1'b0;
    waited = 0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    while (!ok && waited < limit) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_image(input int gap_pct);
    bit ok;
    foreach (img_q[i]) begin
      send_byte(img_q[i], gap_pct, 40, ok);
      if (!ok) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_end();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_done || o_err) got = 1'b1;
    end
    @(posedge clk); #1;
    check("end_reached", {31'd0, got}, 32'd1);
    check("end_done", {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    bit ok;
    logic [7:0] saved_q[$];
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0; sel = 1'b0;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_we", {31'd0, o_we}, 32'd0);
    check("rst_addr", {22'd0, o_addr}, 32'd0);
    check("rst_wdata", o_wdata, 32'd0);
    check("rst_core_rst", {31'd0, o_core_rst}, 32'd1);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word fixed image, no gaps, exact latency of release
    img_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    start_load();
    send_image(0);
    @(negedge clk);
    check("t1_last_we", {31'd0, o_we}, 32'd1);
    check("t1_core_rst_held", {31'd0, o_core_rst}, 32'd1);
    @(negedge clk);
    check("t1_done", {31'd0, o_done}, 32'd1);
    check("t1_core_rst_rel", {31'd0, o_core_rst}, 32'd0);
    @(posedge clk); #1;
    compare_writes(1024);
    $display("t1 fixed two-word load: writes=%0d", addr_q.size());

    // Empty image
    do_reset();
    img_q = '{8'h00, 8'h00};
    start_load();
    send_image(0);
    @(negedge clk);
    check("t2_done", {31'd0, o_done}, 32'd1);
    check("t2_core_rst", {31'd0, o_core_rst}, 32'd0);
    @(posedge clk); #1;
    compare_writes(1024);
    $display("t2 empty image: writes=%0d", addr_q.size());

    // Capacity limits on the small instance
    sel = 1'b1;
    do_reset();
    img_q = '{8'h05, 8'h00};
    start_load();
    send_image(0);
    @(negedge clk);
    check("t3_err", {31'd0, o_err}, 32'd1);
    check("t3_core_rst", {31'd0, o_core_rst}, 32'd1);
    check("t3_ready", {31'd0, o_ready}, 32'd0);
    @(posedge clk); #1;
    send_byte(8'hAA, 0, 8, ok);
    check("t3_no_accept", {31'd0, ok}, 32'd0);
    check("t3_err_stays", {31'd0, o_err}, 32'd1);
    compare_writes(4);
    $display("t3 oversize header: err=%0b", o_err);
    do_reset();
    build_image(4);
    start_load();
    send_image(0);
    wait_end();
    compare_writes(4);
    $display("t3 full capacity load: writes=%0d", addr_q.size());
    sel = 1'b0;

    // Same image with and without source gaps; also reload from DONE
    do_reset();
    build_image(3);
    saved_q = img_q;
    start_load();
    send_image(0);
    wait_end();
    compare_writes(1024);
    $display("t4 three words no gaps: writes=%0d", addr_q.size());
    img_q = saved_q;
    start_load();
    send_image(50);
    wait_end();
    compare_writes(1024);
    $display("t4 three words with gaps: writes=%0d", addr_q.size());
    for (int k = 0; k < 4; k++) begin
      build_image($urandom_range(1, 6));
      start_load();
      send_image(30);
      wait_end();
      compare_writes(1024);
      $display("t4 random load %0d: len=%0d writes=%0d", k, img_q[0], addr_q.size());
    end

    // Reset in the middle of word 1
    do_reset();
    build_image(2);
    start_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(img_q[i], 0, 40, ok);
      if (!ok) check("t5_accept_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_core_rst", {31'd0, o_core_rst}, 32'd1);
    check("t5_done", {31'd0, o_done}, 32'd0);
    check("t5_ready", {31'd0, o_ready}, 32'd0);
    check("t5_we", {31'd0, o_we}, 32'd0);
    check("t5_partial_writes", addr_q.size(), 32'd1);
    @(posedge clk); #1;
    build_image(2);
    start_load();
    send_image(40);
    wait_end();
    compare_writes(1024);
    $display("t5 reload after mid-load reset: writes=%0d", addr_q.size());

    // Reload from DONE with a single word
    img_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    start_load();
    @(negedge clk);
    check("t6_core_rst", {31'd0, o_core_rst}, 32'd1);
    check("t6_done", {31'd0, o_done}, 32'd0);
    @(posedge clk); #1;
    send_image(0);
    wait_end();
    compare_writes(1024);
    check("t6_data", (data_q.size() > 0) ? data_q[0] : 32'd0, 32'hDEADBEEF);
    $display("t6 reload single word: writes=%0d", addr_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
